ps2_kb_rx: RTL
==============

Name: ps2_kb_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the Nios II keyboard-data PIO. It synchronises and filters the keyboard's open-collector clock and data lines and deserialises 11-bit device-to-host frames. It presents the last good scancode byte on an 8-bit bus that drives the PIO's in_port. It also produces a decoded make/break key event for the synth voice logic.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples needed to accept a level change (glitch filter)
TIMEOUT_CYCLES, 100000, clk cycles without a falling ps2_clk edge mid-frame before the frame is aborted (2 ms at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz nominal)
reset_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from connector, asynchronous
ps2_dat  input  1  raw PS/2 data from connector, asynchronous
kb_data  output  8  last correctly received byte, held; drives PIO in_port
kb_valid  output  1  one-cycle pulse when kb_data is updated
kb_err  output  1  set on parity, start, stop or timeout error; cleared on the next good frame
key_code  output  8  decoded scancode of the last make/break event
key_ext  output  1  1 if the last event was prefixed by 0xE0
key_down  output  1  1 = make, 0 = break for the last event
key_event  output  1  one-cycle pulse when key_code, key_ext and key_down update

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; break/extended pending flags cleared; filter state treated as ps2_clk = 1.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - Filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge is a filtered 1->0 transition and is a single-cycle internal strobe (fe).
  - ps2_dat is sampled (synchronised value) in the fe cycle.
- FSM, advancing only on fe:
  - IDLE: if dat = 0 (start bit), go to DATA with bit count 0. If dat = 1, stay in IDLE; this is not an error.
  - DATA: shift dat into bit 7 of the shift register (LSB first). After the 8th bit, go to PARITY.
  - PARITY: store the parity bit, go to STOP.
  - STOP: check odd parity (ones in data plus parity bit must be odd) and stop bit = 1.
    - Both good: kb_data <= byte, kb_valid = 1 and kb_err <= 0 in the next cycle.
    - Either bad: kb_err <= 1; kb_data unchanged; no kb_valid; no decode.
    - Go to IDLE in all cases.
- Latency: kb_valid is high exactly one cycle, the cycle after the stop-bit fe.
- Timeout:
  - Counter resets on every fe and counts while the FSM is not IDLE.
  - Reaching TIMEOUT_CYCLES: go to IDLE, kb_err <= 1, discard the partial byte, no kb_valid.
  - The counter holds at 0 in IDLE.
- Scancode decode, on each good byte (same cycle as kb_valid):
  - 0xE0: set ext_pending; no key_event.
  - 0xF0: set brk_pending; no key_event.
  - Any other byte:
    - key_code <= byte, key_ext <= ext_pending, key_down <= !brk_pending.
    - key_event pulses one cycle, coincident with kb_valid.
    - Both pending flags clear.
  - An error or timeout clears both pending flags.
  - Repeated 0xE0/0xF0 bytes keep the flags set (idempotent).
- kb_valid still pulses for 0xE0 and 0xF0 bytes, because the PIO sees every byte.
- Reset asserted mid-frame: immediate return to reset values; the next frame must start from a fresh start bit.
- No host-to-device transmission; the block never drives ps2_clk or ps2_dat.

Test Plan:
- Reset, then send frame 0x1C (start 0; data bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 12.5 kHz PS/2 clock -> kb_data = 0x1C, kb_valid one pulse, key_event with key_code = 0x1C, key_down = 1, key_ext = 0, kb_err = 0.
- Send bytes F0 then 1C -> two kb_valid pulses (kb_data 0xF0, then 0x1C); a single key_event on the second byte with key_down = 0, key_code = 0x1C.
- Send bytes E0 then 75 -> key_event with key_code = 0x75, key_ext = 1, key_down = 1. Then E0, F0, 75 -> key_ext = 1, key_down = 0.
- Send 0x1C with parity bit 1 -> kb_err = 1, kb_data keeps its previous value, no kb_valid or key_event. A following good 0x29 -> kb_err = 0, kb_data = 0x29.
- Stop the PS/2 clock after 4 data bits -> kb_err = 1 exactly TIMEOUT_CYCLES cycles after the last fe, FSM in IDLE. The next full 0x29 frame is accepted normally.
- Inject 3-cycle low glitches on ps2_clk while idle and mid-frame -> no state change. Frame 0x1C is still received correctly. Assert reset_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines, deserialises
// device-to-host frames and decodes make/break scancode events (0xE0 / 0xF0 prefixes).
module ps2_kb_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kb_data,
    output logic       kb_valid,
    output logic       kb_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_down,
    output logic       key_event
);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3} state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    state_t           state_q, state_d;
    logic             clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       kb_data_q, kb_data_d, key_code_q, key_code_d;
    logic             kb_valid_q, kb_valid_d, kb_err_q, kb_err_d;
    logic             key_ext_q, key_ext_d, key_down_q, key_down_d, key_event_q, key_event_d;
    logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic             fe_s, start_s, shift_en_s, par_en_s, stop_s, timeout_s, good_s, bad_s;

    // Two-flop synchronisers; idle bus level is high on both lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Glitch filter: accept a new clock level after FILTER_LEN consecutive differing samples
    always_comb begin
        clk_filt_d = clk_filt_q;
        flt_cnt_d  = '0;
        fe_s       = 1'b0;
        if (clk_sync_q != clk_filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q;
                fe_s       = clk_filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end else begin
            flt_cnt_d = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, advancing only on filtered falling edges
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = (fe_s && !dat_sync_q) ? S_DATA : S_IDLE;
            S_DATA:   state_d = (fe_s && bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
            S_PARITY: state_d = fe_s ? S_STOP : S_PARITY;
            S_STOP:   state_d = fe_s ? S_IDLE : S_STOP;
            default:  state_d = S_IDLE;
        endcase
        if (timeout_s) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // FSM outputs: per-state strobes, frame verdict
    always_comb begin
        start_s    = 1'b0;
        shift_en_s = 1'b0;
        par_en_s   = 1'b0;
        stop_s     = 1'b0;
        case (state_q)
            S_IDLE:   start_s    = fe_s && !dat_sync_q;
            S_DATA:   shift_en_s = fe_s;
            S_PARITY: par_en_s   = fe_s;
            S_STOP:   stop_s     = fe_s;
            default:  start_s    = 1'b0;
        endcase
        timeout_s = (state_q != S_IDLE) && !fe_s && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        good_s    = stop_s && dat_sync_q && odd_parity_ok(shift_q, par_q);
        bad_s     = (stop_s && !good_s) || timeout_s;
    end

    // Deserialiser, timeout counter and result/decode next-state
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_en_s ? dat_sync_q : par_q;
        if (start_s || timeout_s) begin
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
        end else if (shift_en_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {dat_sync_q, shift_q[7:1]};
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
        if (fe_s || state_q == S_IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        kb_valid_d  = good_s;
        kb_data_d   = good_s ? shift_q : kb_data_q;
        kb_err_d    = bad_s ? 1'b1 : (good_s ? 1'b0 : kb_err_q);
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_down_d  = key_down_q;
        key_event_d = 1'b0;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        if (bad_s) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (good_s) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                key_code_d  = shift_q;
                key_ext_d   = ext_pend_q;
                key_down_d  = !brk_pend_q;
                key_event_d = 1'b1;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
            end
        end else begin
            key_event_d = 1'b0;
        end
    end

    // Datapath and registered output state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q  <= 1'b1;
            flt_cnt_q   <= '0;
            tmo_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            kb_data_q   <= 8'h00;
            kb_valid_q  <= 1'b0;
            kb_err_q    <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_down_q  <= 1'b0;
            key_event_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
        end else begin
            clk_filt_q  <= clk_filt_d;
            flt_cnt_q   <= flt_cnt_d;
            tmo_q       <= tmo_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            kb_data_q   <= kb_data_d;
            kb_valid_q  <= kb_valid_d;
            kb_err_q    <= kb_err_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_down_q  <= key_down_d;
            key_event_q <= key_event_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
        end
    end

    assign kb_data   = kb_data_q;
    assign kb_valid  = kb_valid_q;
    assign kb_err    = kb_err_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_down  = key_down_q;
    assign key_event = key_event_q;
endmodule
